// File: rtl/fetch_buffered.sv
// Buffered fetch stage: issues LANES-wide ROM reads against a credit budget and
// parks returned bundles in a DEPTH-entry FIFO ahead of the decode output register.
module fetch_buffered #(
  parameter int unsigned     LANES    = 2,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     ROM_LAT  = 1,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [31:0]     RESET_PC = 32'h0,
  parameter logic [ILEN-1:0] NOP_WORD = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic [31:0]           rom_addr,
  output logic                  rom_en,
  input  logic [LANES*ILEN-1:0] rom_data,
  output logic                  out_valid,
  output logic [31:0]           out_pc,
  output logic [LANES*ILEN-1:0] out_inst
);

  localparam int unsigned BW = LANES * ILEN;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(ROM_LAT + 1);
  localparam logic [BW-1:0] NOP_BUNDLE = {LANES{NOP_WORD}};

  logic [31:0]   pc;
  logic          tag_v  [ROM_LAT];
  logic [31:0]   tag_pc [ROM_LAT];
  logic [31:0]   mem_pc   [DEPTH];
  logic [BW-1:0] mem_inst [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] fifo_count;
  logic [IW-1:0] inflight;

  logic [31:0] fa;
  logic        credit_ok, fifo_empty, fifo_full;
  logic        ret_v, bypass, push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(ROM_LAT); i++) inflight = inflight + IW'(tag_v[i]);
  end

  // Credits count both buffered bundles and reads still in the ROM, so a push always has a slot.
  assign fa         = redirect ? redirect_pc : pc;
  assign rom_addr   = fa;
  assign credit_ok  = (32'(fifo_count) + 32'(inflight)) < DEPTH;
  assign rom_en     = credit_ok | redirect;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(DEPTH));
  assign ret_v      = tag_v[ROM_LAT-1];
  // An arriving bundle skips the FIFO when it is empty and the output is free to load.
  assign bypass     = ret_v & ~stall & fifo_empty & ~redirect;
  assign push       = ret_v & ~bypass & ~redirect;
  assign pop        = ~stall & ~fifo_empty & ~redirect;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc <= RESET_PC;
      for (int i = 0; i < int'(ROM_LAT); i++) tag_v[i] <= 1'b0;
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_inst   <= NOP_BUNDLE;
    end else begin
      pc <= rom_en ? fa + 32'(LANES) : fa;
      for (int i = int'(ROM_LAT) - 1; i > 0; i--) tag_v[i] <= tag_v[i-1] & ~redirect;
      tag_v[0] <= rom_en;

      if (redirect) begin
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        out_valid  <= 1'b0;
        out_pc     <= '0;
        out_inst   <= NOP_BUNDLE;
      end else begin
        if (push) wr_ptr <= ptr_next(wr_ptr);
        if (pop)  rd_ptr <= ptr_next(rd_ptr);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (!stall) begin
          if (pop) begin
            out_valid <= 1'b1;
            out_pc    <= mem_pc[rd_ptr];
            out_inst  <= mem_inst[rd_ptr];
          end else if (bypass) begin
            out_valid <= 1'b1;
            out_pc    <= tag_pc[ROM_LAT-1];
            out_inst  <= rom_data;
          end else begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= NOP_BUNDLE;
          end
        end
      end
    end
  end

  // NOTE: address tags and FIFO storage carry no reset; the valid bits and count decide what is live.
  always_ff @(posedge clk) begin
    for (int i = int'(ROM_LAT) - 1; i > 0; i--) tag_pc[i] <= tag_pc[i-1];
    tag_pc[0] <= fa;
    if (push) begin
      mem_pc[wr_ptr]   <= tag_pc[ROM_LAT-1];
      mem_inst[wr_ptr] <= rom_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && fifo_full))
    else $error("fetch_buffered: push into full FIFO");

endmodule

// File: tb/tb_fetch_buffered.sv
// Bench for fetch_buffered: two instances (ROM_LAT 1 and 3) share one stimulus stream and are
// checked every cycle against a queue-level fetch model plus hand-computed pins.
module tb_fetch_buffered;

  localparam int unsigned LANES = 2;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned BW    = LANES * ILEN;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [BW-1:0] NOP_B  = '0;
  localparam logic [BW-1:0] POISON = {LANES{32'hDEAD_BEEF}};

  logic clk = 1'b0;
  logic rstn = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic          rom_en_a, rom_en_b, out_valid_a, out_valid_b;
  logic [31:0]   rom_addr_a, rom_addr_b, out_pc_a, out_pc_b;
  logic [BW-1:0] rom_data_a, rom_data_b, out_inst_a, out_inst_b, rb1, rb2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_buffered #(.LANES(LANES), .ILEN(ILEN), .ROM_LAT(LAT_A), .DEPTH(DEPTH),
                   .RESET_PC(RESET_PC), .NOP_WORD(32'h0)) dut_a (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr_a), .rom_en(rom_en_a), .rom_data(rom_data_a),
    .out_valid(out_valid_a), .out_pc(out_pc_a), .out_inst(out_inst_a));

  fetch_buffered #(.LANES(LANES), .ILEN(ILEN), .ROM_LAT(LAT_B), .DEPTH(DEPTH),
                   .RESET_PC(RESET_PC), .NOP_WORD(32'h0)) dut_b (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr_b), .rom_en(rom_en_b), .rom_data(rom_data_b),
    .out_valid(out_valid_b), .out_pc(out_pc_b), .out_inst(out_inst_b));

  // ROM contents: each lane word is a fixed function of its own word address.
  function automatic logic [BW-1:0] bundle(input logic [31:0] a);
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < int'(LANES); k++) b[k*ILEN +: ILEN] = 32'h5A00_0000 ^ (a + 32'(k));
    return b;
  endfunction

  always @(posedge clk) rom_data_a <= rom_en_a ? bundle(rom_addr_a) : POISON;
  always @(posedge clk) begin
    rb1        <= rom_en_b ? bundle(rom_addr_b) : POISON;
    rb2        <= rb1;
    rom_data_b <= rb2;
  end

  // Model: list of reads in the ROM with due cycles, list of buffered bundle addresses.
  logic [31:0] m_pc     [2];
  logic [31:0] fly_pc   [2][8];
  int          fly_due  [2][8];
  int          fly_n    [2];
  logic [31:0] buf_pc   [2][8];
  int          buf_n    [2];
  logic        m_valid  [2];
  logic [31:0] m_out_pc [2];
  int cyc = 0;
  bit live = 1'b0;

  function automatic int lat_of(input int k);
    return (k == 0) ? int'(LAT_A) : int'(LAT_B);
  endfunction

  function automatic logic exp_en(input int k);
    return redirect || ((buf_n[k] + fly_n[k]) < int'(DEPTH));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    logic [31:0] fa;
    logic en;
    if (!rstn) begin
      m_pc[k] = RESET_PC; fly_n[k] = 0; buf_n[k] = 0; m_valid[k] = 1'b0; m_out_pc[k] = '0;
      return;
    end
    fa = redirect ? redirect_pc : m_pc[k];
    en = exp_en(k);
    if (redirect) begin
      fly_n[k] = 0; buf_n[k] = 0; m_valid[k] = 1'b0; m_out_pc[k] = '0;
    end else begin
      if (fly_n[k] > 0 && fly_due[k][0] == cyc) begin
        if (buf_n[k] < 8) begin buf_pc[k][buf_n[k]] = fly_pc[k][0]; buf_n[k]++; end
        for (int i = 1; i < fly_n[k]; i++) begin
          fly_pc[k][i-1] = fly_pc[k][i]; fly_due[k][i-1] = fly_due[k][i];
        end
        fly_n[k]--;
      end
      if (!stall) begin
        if (buf_n[k] > 0) begin
          m_valid[k] = 1'b1; m_out_pc[k] = buf_pc[k][0];
          for (int i = 1; i < buf_n[k]; i++) buf_pc[k][i-1] = buf_pc[k][i];
          buf_n[k]--;
        end else begin
          m_valid[k] = 1'b0; m_out_pc[k] = '0;
        end
      end
    end
    if (en && fly_n[k] < 8) begin
      fly_pc[k][fly_n[k]] = fa; fly_due[k][fly_n[k]] = cyc + lat_of(k); fly_n[k]++;
    end
    m_pc[k] = en ? fa + 32'(LANES) : fa;
  endtask

  task automatic cmp(input int k, input logic en, input logic [31:0] addr, input logic v,
                     input logic [31:0] pc, input logic [BW-1:0] inst);
    logic [31:0] efa;
    logic [BW-1:0] einst;
    efa   = redirect ? redirect_pc : m_pc[k];
    einst = m_valid[k] ? bundle(m_out_pc[k]) : NOP_B;
    check($sformatf("rom_en[%0d]@%0d", k, cyc),    64'(en),   64'(exp_en(k)));
    check($sformatf("rom_addr[%0d]@%0d", k, cyc),  64'(addr), 64'(efa));
    check($sformatf("out_valid[%0d]@%0d", k, cyc), 64'(v),    64'(m_valid[k]));
    check($sformatf("out_pc[%0d]@%0d", k, cyc),    64'(pc),   64'(m_out_pc[k]));
    check($sformatf("out_inst[%0d]@%0d", k, cyc),  64'(inst), 64'(einst));
  endtask

  task automatic tick();
    @(negedge clk);
    if (live) begin
      cmp(0, rom_en_a, rom_addr_a, out_valid_a, out_pc_a, out_inst_a);
      cmp(1, rom_en_b, rom_addr_b, out_valid_b, out_pc_b, out_inst_b);
    end
    @(posedge clk);
    model_step(0);
    model_step(1);
    if (!rstn) live = 1'b1;
    cyc++;
    #1;
  endtask

  initial begin
    int nv;
    // Reset state
    tick(); tick();
    check("rst_valid_a", 64'(out_valid_a), 64'(1'b0));
    check("rst_pc_a",    64'(out_pc_a),    64'(32'h0));
    check("rst_inst_a",  64'(out_inst_a),  64'(NOP_B));
    check("rst_valid_b", 64'(out_valid_b), 64'(1'b0));

    // Startup and free run
    rstn = 1'b1;
    tick();
    check("start_c1_valid_a", 64'(out_valid_a), 64'(1'b0));
    tick();
    check("start_c2_valid_a", 64'(out_valid_a), 64'(1'b1));
    check("start_c2_pc_a",    64'(out_pc_a),    64'(32'h0));
    check("start_c2_inst_a",  64'(out_inst_a),  64'(bundle(32'h0)));
    tick();
    check("start_c3_pc_a",    64'(out_pc_a),    64'(32'h2));
    check("start_c3_valid_b", 64'(out_valid_b), 64'(1'b0));
    tick();
    check("start_c4_pc_a",    64'(out_pc_a),    64'(32'h4));
    check("start_c4_valid_b", 64'(out_valid_b), 64'(1'b1));
    check("start_c4_pc_b",    64'(out_pc_b),    64'(32'h0));
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      nv += int'(out_valid_b);
    end
    check("lat3_throughput_b", 64'(nv), 64'(6));
    check("run_c10_pc_a", 64'(out_pc_a), 64'(32'd16));
    check("run_c10_pc_b", 64'(out_pc_b), 64'(32'd12));

    // Six-cycle stall: output holds, credits run out, resume without gap
    stall = 1'b1;
    repeat (5) tick();
    check("stall_en_off_a", 64'(rom_en_a), 64'(1'b0));
    check("stall_en_off_b", 64'(rom_en_b), 64'(1'b0));
    check("stall_hold_a",   64'(out_pc_a), 64'(32'd16));
    check("stall_hold_b",   64'(out_pc_b), 64'(32'd12));
    tick();
    stall = 1'b0;
    check("stall_last_hold_a", 64'(out_pc_a), 64'(32'd16));
    tick();
    check("resume_pc_a", 64'(out_pc_a), 64'(32'd18));
    check("resume_pc_b", 64'(out_pc_b), 64'(32'd14));
    tick();
    check("resume2_pc_a", 64'(out_pc_a), 64'(32'd20));
    check("resume2_pc_b", 64'(out_pc_b), 64'(32'd16));

    // Redirect with buffered entries
    repeat (4) tick();
    stall = 1'b1;
    tick();
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("redir_bubble_a", 64'(out_valid_a), 64'(1'b0));
    check("redir_bubble_b", 64'(out_valid_b), 64'(1'b0));
    tick();
    check("redir_tgt_valid_a", 64'(out_valid_a), 64'(1'b1));
    check("redir_tgt_pc_a",    64'(out_pc_a),    64'(32'h40));
    tick();
    check("redir_next_pc_a", 64'(out_pc_a),    64'(32'h42));
    check("redir_wait_b",    64'(out_valid_b), 64'(1'b0));
    tick();
    check("redir_tgt_pc_b", 64'(out_pc_b), 64'(32'h40));

    // Redirect while stalled
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    check("rs_bubble_a", 64'(out_valid_a), 64'(1'b0));
    check("rs_bubble_b", 64'(out_valid_b), 64'(1'b0));
    repeat (3) tick();
    check("rs_hold_a", 64'(out_valid_a), 64'(1'b0));
    stall = 1'b0;
    tick();
    check("rs_tgt_pc_a", 64'(out_pc_a),    64'(32'h80));
    check("rs_tgt_v_a",  64'(out_valid_a), 64'(1'b1));
    check("rs_tgt_pc_b", 64'(out_pc_b),    64'(32'h80));
    tick();
    check("rs_next_pc_a", 64'(out_pc_a), 64'(32'h82));
    check("rs_next_pc_b", 64'(out_pc_b), 64'(32'h82));

    // 32-bit wrap of the fetch address
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    check("wrap_pc0_a", 64'(out_pc_a), 64'(32'hFFFF_FFFC));
    tick();
    check("wrap_pc1_a", 64'(out_pc_a), 64'(32'hFFFF_FFFE));
    tick();
    check("wrap_pc2_a",   64'(out_pc_a),    64'(32'h0));
    check("wrap_valid_a", 64'(out_valid_a), 64'(1'b1));
    check("wrap_pc0_b",   64'(out_pc_b),    64'(32'hFFFF_FFFC));

    // Reset mid-stream with reads in flight
    repeat (2) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mrst_valid_a", 64'(out_valid_a), 64'(1'b0));
    check("mrst_pc_a",    64'(out_pc_a),    64'(32'h0));
    check("mrst_inst_a",  64'(out_inst_a),  64'(NOP_B));
    check("mrst_valid_b", 64'(out_valid_b), 64'(1'b0));
    tick();
    check("mrst_c1_valid_a", 64'(out_valid_a), 64'(1'b0));
    tick();
    check("mrst_first_v_a",  64'(out_valid_a), 64'(1'b1));
    check("mrst_first_pc_a", 64'(out_pc_a),    64'(RESET_PC));
    tick();
    check("mrst_wait_b", 64'(out_valid_b), 64'(1'b0));
    tick();
    check("mrst_first_v_b",  64'(out_valid_b), 64'(1'b1));
    check("mrst_first_pc_b", 64'(out_pc_b),    64'(RESET_PC));
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
